// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit: owns architectural HI/LO, accepts MULT/DIV/MTHI/MTLO
// and holds busy for a fixed latency before committing the result.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;
    localparam logic [1:0] K_MULT  = 2'b00;
    localparam logic [1:0] K_MULTU = 2'b01;
    localparam logic [1:0] K_DIV   = 2'b10;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_ok;

    // Result of the captured operation; divide works on magnitudes, signs fixed up afterwards.
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'b0, a_q} * {32'b0, b_q};
        dvd    = (op_q == K_DIV && a_q[31]) ? 32'(-a_q) : a_q;
        dvs    = (op_q == K_DIV && b_q[31]) ? 32'(-b_q) : b_q;
        quo    = dvd / ((dvs == 32'd0) ? 32'd1 : dvs);
        rem    = dvd % ((dvs == 32'd0) ? 32'd1 : dvs);
        res_hi = rem;
        res_lo = quo;
        res_ok = (b_q != 32'd0);
        case (op_q)
            K_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
                res_ok = 1'b1;
            end
            K_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
                res_ok = 1'b1;
            end
            K_DIV: begin
                res_lo = (a_q[31] ^ b_q[31]) ? 32'(-quo) : quo;
                res_hi = a_q[31] ? 32'(-rem) : rem;
            end
            default: ;
        endcase
    end

    // Accept when idle, count down while busy, commit HI/LO on the final edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy <= 1'b0;
            hi   <= 32'd0;
            lo   <= 32'd0;
            cnt  <= '0;
            op_q <= 2'b00;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
        end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
                if (res_ok) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end
        end else if (start) begin
            if (!op[2]) begin
                op_q <= op[1:0];
                a_q  <= a;
                b_q  <= b;
                cnt  <= op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                busy <= 1'b1;
            end else if (op == OP_MTHI) begin
                hi <= a;
            end else if (op == OP_MTLO) begin
                lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: a cycle-level reference model compared every cycle,
// plus directed operations with hand-computed results and busy-window lengths.
module tb_e_mdu;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b111;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference model: a pending result plus the edge number on which it lands.
    int          cyc = 0;
    bit          pend = 1'b0;
    int          done_at = 0;
    bit          p_ok = 1'b0;
    logic [31:0] p_hi = 32'd0;
    logic [31:0] p_lo = 32'd0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always @(posedge clk) begin
        int sa, sb;
        longint sp, sq, sr;
        longint unsigned ua, ub, up;
        cyc++;
        if (!reset) begin
            pend = 1'b0;
            m_hi = 32'd0;
            m_lo = 32'd0;
        end else if (pend) begin
            if (cyc == done_at) begin
                pend = 1'b0;
                if (p_ok) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
            end
        end else if (start) begin
            sa = a; sb = b; ua = 64'(a); ub = 64'(b);
            p_ok = 1'b1;
            case (op)
                3'b000: begin sp = longint'(sa) * longint'(sb); p_hi = sp[63:32]; p_lo = sp[31:0]; end
                3'b001: begin up = ua * ub; p_hi = up[63:32]; p_lo = up[31:0]; end
                3'b010: begin
                    if (b == 32'd0) p_ok = 1'b0;
                    else begin
                        sq = longint'(sa) / longint'(sb);
                        sr = longint'(sa) % longint'(sb);
                        p_lo = sq[31:0]; p_hi = sr[31:0];
                    end
                end
                3'b011: begin
                    if (b == 32'd0) p_ok = 1'b0;
                    else begin
                        up = ua / ub; p_lo = up[31:0];
                        up = ua % ub; p_hi = up[31:0];
                    end
                end
                3'b100: m_hi = a;
                3'b101: m_lo = a;
                default: ;
            endcase
            if (!op[2]) begin
                pend = 1'b1;
                done_at = cyc + (op[1] ? DIV_N : MULT_N);
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (busy !== pend || hi !== m_hi || lo !== m_lo) begin
                errors++;
                $display("FAIL model t=%0t busy=%b hi=%h lo=%h required busy=%b hi=%h lo=%h",
                         $time, busy, hi, lo, pend, m_hi, m_lo);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Present a one-cycle start; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 3'b111;
    endtask

    // Issue an op and measure the busy window (bounded).
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int unsigned n);
        int cnt;
        logic [31:0] old_hi, old_lo;
        old_hi = hi; old_lo = lo;
        issue(o, x, y);
        cnt = 0;
        while (busy === 1'b1 && cnt < 50) begin
            if (cnt == int'(n) - 1) begin
                check({name, "_hold_hi"}, hi, old_hi);
                check({name, "_hold_lo"}, lo, old_lo);
            end
            cnt++;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 32'(cnt), 32'(n));
    endtask

    initial begin
        int k;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op("mult", 3'b000, 32'hFFFFFFFF, 32'h00000002, MULT_N);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFE);

        run_op("multu", 3'b001, 32'hFFFFFFFF, 32'h00000002, MULT_N);
        check("multu_hi", hi, 32'h00000001);
        check("multu_lo", lo, 32'hFFFFFFFE);

        run_op("div", 3'b010, 32'hFFFFFFF9, 32'h00000002, DIV_N);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);

        run_op("divu", 3'b011, 32'd7, 32'd2, DIV_N);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        issue(3'b100, 32'h11111111, 32'd0);
        check("mthi_busy", 32'(busy), 32'd0);
        check("mthi_hi", hi, 32'h11111111);
        issue(3'b101, 32'h22222222, 32'd0);
        check("mtlo_lo", lo, 32'h22222222);

        run_op("div0", 3'b010, 32'd100, 32'd0, DIV_N);
        check("div0_hi", hi, 32'h11111111);
        check("div0_lo", lo, 32'h22222222);

        run_op("divovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, DIV_N);
        check("divovf_lo", lo, 32'h80000000);
        check("divovf_hi", hi, 32'd0);

        // Contention: ops offered while busy are dropped.
        issue(3'b000, 32'd3, 32'd4);
        issue(3'b101, 32'hDEADBEEF, 32'd0);
        check("contend_lo_held", lo, 32'h80000000);
        issue(3'b011, 32'd9, 32'd2);
        k = 0;
        while (busy === 1'b1 && k < 50) begin k++; @(negedge clk); end
        check("contend_hi", hi, 32'd0);
        check("contend_lo", lo, 32'd12);
        check("contend_busy", 32'(busy), 32'd0);

        // Back-to-back: issued on the cycle busy fell, then a no-op.
        run_op("b2b", 3'b001, 32'h00010000, 32'h00010000, MULT_N);
        check("b2b_hi", hi, 32'd1);
        check("b2b_lo", lo, 32'd0);
        issue(3'b110, 32'h55555555, 32'd0);
        check("noop_busy", 32'(busy), 32'd0);
        check("noop_hi", hi, 32'd1);

        // Reset mid-MULT discards the result.
        issue(3'b100, 32'd5, 32'd0);
        issue(3'b000, 32'd3, 32'd5);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        reset = 1'b1;
        repeat (MULT_N + 3) @(negedge clk);
        check("nolate_hi", hi, 32'd0);
        check("nolate_lo", lo, 32'd0);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
# e_mdu

Multi-cycle multiply/divide unit in the EX stage of the 5-stage pipelined MIPS core. It executes MULT, MULTU, DIV and DIVU, as well as MTHI and MTLO. It holds the architectural HI/LO registers and drives `busy` so the hazard logic can stall MDU-dependent instructions in D. Results appear on `hi`/`lo` only after a fixed latency, which models a real iterative multiplier/divider.

## Interface
- `MULT_CYCLES`, 5: busy duration for MULT/MULTU.
- `DIV_CYCLES`, 10: busy duration for DIV/DIVU.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low; `reset==0` at a rising edge resets all state.
- `start`  in  1  single-cycle request; qualified by `op`.
- `op`  in  3  operation code:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU
  - 100 MTHI, 101 MTLO
  - 11x no-op
- `a`  in  32  rs operand (dividend or multiplicand; MTHI/MTLO source).
- `b`  in  32  rt operand (divisor or multiplier).
- `busy`  out  1  high while a MULT/DIV is in flight.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.

## Operation
- Reset (`reset==0` at an edge):
  - `busy`, `hi`, `lo` and the internal counter are all cleared to 0.
  - Any in-flight operation is discarded and its result is never written.
  - Reset has priority over `start`.
- Accept rule: `start` is sampled only when `busy==0`. When `busy==1`, `start` is ignored entirely; the op is not queued and `hi`/`lo` are not touched.
- MULT/MULTU/DIV/DIVU accepted at edge E0:
  - Operands and op are captured at E0.
  - The counter is loaded with N (`MULT_CYCLES` or `DIV_CYCLES`) and `busy` is set to 1.
- Each subsequent edge while busy decrements the counter. At the edge where the counter reaches 0, the result is written to `hi`/`lo` and `busy` is cleared in the same edge.
- `hi`/`lo` keep their old values throughout the busy window.
- Arithmetic:
  - MULT: 64-bit signed product of `a`,`b`; `hi` = [63:32], `lo` = [31:0].
  - MULTU: same as MULT, but the product is unsigned.
  - DIV: signed divide. `lo` = quotient truncated toward zero; `hi` = remainder, which takes the sign of the dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0.
  - DIVU: unsigned quotient in `lo`, unsigned remainder in `hi`.
  - Divide by zero (DIV/DIVU with `b==0`): `busy` still runs the full `DIV_CYCLES`, and `hi`/`lo` are left unchanged at completion.
- MTHI/MTLO accepted at an edge (`busy==0`):
  - `hi` (or `lo`) is loaded with `a` at that same edge.
  - `busy` stays 0; there is no multi-cycle latency.
- No-op codes: no state change.
- The pipeline hazard unit stalls D on MDU instructions when `busy | start`. `e_mdu` never sees MFHI/MFLO; those read `hi`/`lo` combinationally.

## Timing
- `busy` rises one cycle after the `start` edge (registered) and stays high for exactly N cycles.
- `hi`/`lo` update on the same edge that `busy` falls.
- Back-to-back: a new `start` presented in the cycle where `busy` has just fallen is accepted at the next edge. The minimum spacing is therefore N+1 cycles between start edges.
- MTHI/MTLO: 1-cycle latency; the new value is visible in the cycle after the edge.
- Reset asserted mid-operation: on the next edge `busy` becomes 0 and `hi`/`lo` become 0. No late write of the discarded result ever occurs.
- Outputs are purely registered; there is no combinational path from inputs to outputs.

## Test plan
- MULT, `a=0xFFFFFFFF`, `b=0x00000002`:
  - `busy` is high for 5 cycles.
  - On its falling edge, `hi=0xFFFFFFFF`, `lo=0xFFFFFFFE`.
  - `hi`/`lo` hold their prior values before that edge.
- MULTU with the same operands -> `hi=0x00000001`, `lo=0xFFFFFFFE` after 5 cycles.
- DIV, `a=0xFFFFFFF9` (-7), `b=2`: `busy` is high for 10 cycles, then `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`.
- DIVU, `a=7`, `b=2` -> `lo=3`, `hi=1` after 10 cycles.
- Divide by zero: after MTHI `0x11111111` and MTLO `0x22222222`, DIV with `b=0` -> `busy` runs 10 cycles, and `hi`/`lo` remain `0x11111111`/`0x22222222`.
- Contention and reset:
  - MTLO with `a=0xDEADBEEF` while `busy==1` is ignored.
  - Asserting `reset=0` at cycle 3 of a MULT -> next edge gives `busy=0`, `hi=lo=0`.
  - No write occurs at the original completion cycle.
